// File: rtl/toothless_lsu_pkg.sv
// Shared LSU types: FSM state encoding and funct3 size/sign codes.
package toothless_lsu_pkg;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_WAIT_GNT,
      LSU_WAIT_RVALID
   } lsu_state_e;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/toothless_lsu_if.sv
// OBI-style data-memory bus: req/gnt address phase, rvalid response phase.
interface toothless_lsu_if;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/toothless_lsu_align.sv
// Combinational lane steering for stores, extract/extend for loads, illegal-access detect.
// Zero latency; no flow control of its own.
module toothless_lsu_align
   import toothless_lsu_pkg::*;
(
   input  logic        st_we,
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wdata,
   output logic [3:0]  be,
   output logic [31:0] lane_wdata,
   output logic        illegal,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ld_data
);
   logic [15:0] lane;

   always_comb begin
      be         = 4'b0000;
      lane_wdata = st_wdata;
      illegal    = 1'b0;
      case (st_funct3)
         LSU_B, LSU_BU: begin
            be         = 4'b0001 << st_off;
            lane_wdata = {4{st_wdata[7:0]}};
         end
         LSU_H, LSU_HU: begin
            be         = 4'b0011 << st_off;
            lane_wdata = {2{st_wdata[15:0]}};
            illegal    = st_off[0];
         end
         LSU_W: begin
            be      = 4'b1111;
            illegal = (st_off != 2'b00);
         end
         default: illegal = 1'b1;
      endcase
      // Unsigned variants only exist for loads
      if (st_we && (st_funct3 == LSU_BU || st_funct3 == LSU_HU))
         illegal = 1'b1;
   end

   always_comb begin
      lane = 16'(mem_rdata >> {ld_off, 3'b000});
      case (ld_funct3)
         LSU_B:   ld_data = {{24{lane[7]}}, lane[7:0]};
         LSU_BU:  ld_data = {24'b0, lane[7:0]};
         LSU_H:   ld_data = {{16{lane[15]}}, lane[15:0]};
         LSU_HU:  ld_data = {16'b0, lane[15:0]};
         default: ld_data = mem_rdata;
      endcase
   end
endmodule

// File: rtl/toothless_lsu.sv
// RV32I load/store unit: one OBI transaction at a time, registered done/err/rdata.
// Zero-wait latency accept->done is 3 cycles; lsu_busy_o stalls the pipeline while not idle.
module toothless_lsu
   import toothless_lsu_pkg::*;
#(
   parameter int unsigned GNT_TIMEOUT = 0
)(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_funct3_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic        lsu_busy_o,
   output logic        lsu_done_o,
   output logic        lsu_err_o,
   output logic [31:0] lsu_rdata_o,
   toothless_lsu_if.master data
);
   localparam int unsigned   CW       = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((GNT_TIMEOUT == 0) ? 32'd0 : GNT_TIMEOUT - 1);

   lsu_state_e  state;
   logic        req_q, we_q, done_q, err_q, late_ok_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  be_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [CW-1:0] cnt_q;

   logic [3:0]  st_be;
   logic [31:0] st_wdata, ld_data;
   logic        illegal;

   toothless_lsu_align u_align (
      .st_we      (lsu_we_i),
      .st_funct3  (lsu_funct3_i),
      .st_off     (lsu_addr_i[1:0]),
      .st_wdata   (lsu_wdata_i),
      .be         (st_be),
      .lane_wdata (st_wdata),
      .illegal    (illegal),
      .ld_funct3  (funct3_q),
      .ld_off     (off_q),
      .mem_rdata  (data.rdata),
      .ld_data    (ld_data)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state     <= LSU_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         funct3_q  <= '0;
         off_q     <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         // A response belonging to an aborted transaction may still arrive
         late_ok_q <= 1'b1;
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         case (state)
            LSU_IDLE: begin
               if (lsu_req_i) begin
                  late_ok_q <= 1'b0;
                  if (illegal) begin
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end else begin
                     state    <= LSU_WAIT_GNT;
                     req_q    <= 1'b1;
                     we_q     <= lsu_we_i;
                     addr_q   <= {lsu_addr_i[31:2], 2'b00};
                     be_q     <= st_be;
                     wdata_q  <= st_wdata;
                     funct3_q <= lsu_funct3_i;
                     off_q    <= lsu_addr_i[1:0];
                     cnt_q    <= '0;
                  end
               end
            end
            LSU_WAIT_GNT: begin
               if (data.gnt) begin
                  state <= LSU_WAIT_RVALID;
                  req_q <= 1'b0;
               end else if (GNT_TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                  state  <= LSU_IDLE;
                  req_q  <= 1'b0;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end else if (GNT_TIMEOUT != 0) begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            LSU_WAIT_RVALID: begin
               if (data.rvalid) begin
                  state   <= LSU_IDLE;
                  done_q  <= 1'b1;
                  err_q   <= data.err;
                  rdata_q <= (!we_q && !data.err) ? ld_data : 32'd0;
               end
            end
            default: state <= LSU_IDLE;
         endcase
      end
   end

   assign lsu_busy_o  = (state != LSU_IDLE);
   assign lsu_done_o  = done_q;
   assign lsu_err_o   = err_q;
   assign lsu_rdata_o = rdata_q;

   assign data.req   = req_q;
   assign data.addr  = addr_q;
   assign data.we    = we_q;
   assign data.be    = be_q;
   assign data.wdata = wdata_q;

   rvalid_unexpected: assert property (@(posedge clk_i) disable iff (!rst_ni)
      data.rvalid |-> (state == LSU_WAIT_RVALID) || (state == LSU_IDLE && late_ok_q));
endmodule
